fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage that owns the architectural fetch PC and drives the instruction SRAM. It sits directly downstream of the branch predictor: it presents the current fetch PC to the predictor and advances to the predictor's `bp_next_pc` when a request is accepted. It delivers each fetched instruction, its PC and the prediction taken for it to the decode stage. It also handles decode-stage redirects (mispredict or flush), including discarding stale SRAM responses.

## Interface
- `RESET_PC`, default 32'h1c000000, first fetch address after reset.
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `bp_pc`  out  32  PC presented to the predictor; always equals `fetch_pc`.
- `bp_next_pc`  in  32  predicted next PC for `bp_pc` (combinational from the predictor).
- `bp_taken`  in  1  predicted taken for `bp_pc`.
- `inst_sram_req`  out  1  fetch request valid.
- `inst_sram_addr`  out  32  `{fetch_pc[31:2],2'b00}`.
- `inst_sram_addr_ok`  in  1  request accepted this cycle.
- `inst_sram_data_ok`  in  1  response valid this cycle; responses arrive in order.
- `inst_sram_rdata`  in  32  instruction word.
- `redirect_valid`  in  1  decode-stage redirect; one-cycle pulse.
- `redirect_pc`  in  32  corrected fetch PC.
- `fs_to_ds_valid`  out  1  output register holds a valid instruction.
- `fs_to_ds_bus`  out  97  `[96:65]` pc, `[64:33]` inst, `[32]` pred_taken, `[31:0]` pred_target.
- `ds_allowin`  in  1  decode stage accepts the bus this cycle.

## Operation
- Registers:
  - `fetch_pc` (32 bits).
  - `state`, one of S_REQ, S_WAIT, S_FULL, S_DROP.
  - Latched `req_pc`, `req_taken`, `req_target`.
  - Output register (valid plus bus).
- At most one outstanding SRAM request.
- S_REQ:
  - `inst_sram_req` = 1.
  - On `addr_ok`: latch `req_pc`←`fetch_pc`, `req_taken`←`bp_taken`, `req_target`←`bp_next_pc`; set `fetch_pc`←`bp_next_pc`; go to S_WAIT.
- S_WAIT:
  - `req` = 0.
  - On `data_ok`: load the output register with {`req_pc`, `rdata`, `req_taken`, `req_target`}; set valid = 1; go to S_FULL.
- S_FULL:
  - `req` = 0.
  - On `ds_allowin`: clear valid; go to S_REQ.
- S_DROP:
  - `req` = 0.
  - On `data_ok`: discard `rdata`; go to S_REQ.
- Redirect has priority over all other transitions in the same cycle:
  - Always: `fetch_pc`←`redirect_pc` and output valid←0.
  - S_REQ with `addr_ok` the same cycle: the request is accepted but is stale; go to S_DROP. `fetch_pc` is not updated from the predictor.
  - S_REQ without `addr_ok`: stay in S_REQ. `inst_sram_addr` switches to the new PC next cycle (legal, because the request was not accepted).
  - S_WAIT without `data_ok`: go to S_DROP.
  - S_WAIT with `data_ok`: discard the response; go to S_REQ.
  - S_FULL: go to S_REQ. Output valid is cleared even if `ds_allowin` is high that cycle, so decode must ignore the bus on a redirect cycle.
  - S_DROP without `data_ok`: stay in S_DROP. S_DROP with `data_ok`: go to S_REQ.
- `pred_target` always equals the predictor's next PC: `pc+4` when predicted not-taken.
- `redirect_pc[1:0]` is ignored for addressing; the SRAM address is forced word-aligned.

## Timing
- Reset values:
  - `fetch_pc` = `RESET_PC`; state = S_REQ.
  - `inst_sram_req` = 0 while `reset` is high.
  - `fs_to_ds_valid` = 0; `fs_to_ds_bus` = 0.
  - `bp_pc` = `RESET_PC`.
- Reset mid-operation returns to this state. A response still pending from before reset is not tracked; the SRAM is reset together with this block.
- `inst_sram_req` is combinational from state: high in S_REQ only and not during reset. It is first high in the cycle after `reset` falls.
- Best-case latency:
  - `addr_ok` in cycle T, `data_ok` in T+1, so `fs_to_ds_valid` = 1 in T+2.
  - Consumed in T+2, so the next `req` is in T+3.
  - Peak throughput is one instruction per 3 cycles.
- After a redirect in cycle R:
  - `inst_sram_addr` = `redirect_pc` from R+1 (no pending response), or from the cycle after the stale `data_ok`.
  - `fs_to_ds_valid` = 0 from R+1.

## Test plan
- **Reset and sequential fetch.** Reset then release; `addr_ok` and `data_ok` always 1; predictor not-taken. Required: addresses 1c000000, 1c000004, 1c000008. Each bus shows pc, inst, `pred_taken`=0, `pred_target`=pc+4.
- **Predicted taken.** At pc 1c000010, `bp_taken`=1 and `bp_next_pc`=1c000100. Required: bus for 1c000010 has `pred_taken`=1, target 1c000100; next request address is 1c000100.
- **Backpressure.** `ds_allowin`=0 for 5 cycles while S_FULL. Required: bus stable, `req`=0 throughout; the next `req` occurs the cycle after `ds_allowin`=1.
- **Redirect while waiting.** Request 1c000020 accepted; redirect to 1c000200 before `data_ok`; response arrives 3 cycles later. Required: that response is never presented to decode; the next request address is 1c000200.
- **Simultaneous redirect and `addr_ok`.** In S_REQ, `redirect_pc`=1c000300. Required: the accepted request's response is dropped; then a request to 1c000300 is issued.
- **Redirect in S_FULL with `ds_allowin`=1.** Required: valid cleared; the next request is to `redirect_pc`.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: owns the fetch PC, issues one instruction SRAM request at a time,
// hands each word to decode and drops responses made stale by a redirect.
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c000000
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] bp_pc,
    input  logic [31:0] bp_next_pc,
    input  logic        bp_taken,
    output logic        inst_sram_req,
    output logic [31:0] inst_sram_addr,
    input  logic        inst_sram_addr_ok,
    input  logic        inst_sram_data_ok,
    input  logic [31:0] inst_sram_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fs_to_ds_valid,
    output logic [96:0] fs_to_ds_bus,
    input  logic        ds_allowin
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_FULL,
        S_DROP
    } state_t;

    state_t      state_q;
    logic [31:0] fetch_pc_q;
    logic [31:0] req_pc_q;
    logic        req_taken_q;
    logic [31:0] req_target_q;
    logic        valid_q;
    logic [96:0] bus_q;

    assign bp_pc          = fetch_pc_q;
    assign inst_sram_req  = (state_q == S_REQ) && !reset;
    assign inst_sram_addr = {fetch_pc_q[31:2], 2'b00};
    assign fs_to_ds_valid = valid_q;
    assign fs_to_ds_bus   = bus_q;

    // Fetch FSM: redirect overrides every other transition in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_REQ;
            fetch_pc_q   <= RESET_PC;
            req_pc_q     <= 32'h0;
            req_taken_q  <= 1'b0;
            req_target_q <= 32'h0;
            valid_q      <= 1'b0;
            bus_q        <= 97'h0;
        end else if (redirect_valid) begin
            fetch_pc_q <= redirect_pc;
            valid_q    <= 1'b0;
            case (state_q)
                S_REQ: begin
                    if (inst_sram_addr_ok) state_q <= S_DROP;
                end
                S_WAIT: begin
                    state_q <= inst_sram_data_ok ? S_REQ : S_DROP;
                end
                S_FULL: begin
                    state_q <= S_REQ;
                end
                S_DROP: begin
                    if (inst_sram_data_ok) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end else begin
            case (state_q)
                S_REQ: begin
                    if (inst_sram_addr_ok) begin
                        req_pc_q     <= fetch_pc_q;
                        req_taken_q  <= bp_taken;
                        req_target_q <= bp_next_pc;
                        fetch_pc_q   <= bp_next_pc;
                        state_q      <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (inst_sram_data_ok) begin
                        bus_q   <= {req_pc_q, inst_sram_rdata,
                                    req_taken_q, req_target_q};
                        valid_q <= 1'b1;
                        state_q <= S_FULL;
                    end
                end
                S_FULL: begin
                    if (ds_allowin) begin
                        valid_q <= 1'b0;
                        state_q <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (inst_sram_data_ok) state_q <= S_REQ;
                end
                default: state_q <= S_REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: scoreboard bench with an SRAM/predictor model and a
// transaction-level expectation queue that a redirect empties.
module tb_fetch_stage;

    localparam logic [31:0] RST = 32'h1c000000;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] bp_pc;
    logic [31:0] bp_next_pc;
    logic        bp_taken;
    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fs_to_ds_valid;
    logic [96:0] fs_to_ds_bus;
    logic        ds_allowin;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(RST)) dut (
        .clk              (clk),
        .reset            (reset),
        .bp_pc            (bp_pc),
        .bp_next_pc       (bp_next_pc),
        .bp_taken         (bp_taken),
        .inst_sram_req    (inst_sram_req),
        .inst_sram_addr   (inst_sram_addr),
        .inst_sram_addr_ok(inst_sram_addr_ok),
        .inst_sram_data_ok(inst_sram_data_ok),
        .inst_sram_rdata  (inst_sram_rdata),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .fs_to_ds_valid   (fs_to_ds_valid),
        .fs_to_ds_bus     (fs_to_ds_bus),
        .ds_allowin       (ds_allowin)
    );

    int tests = 0;
    int fails = 0;
    int consumed = 0;
    int mode = 0;
    int cyc = 0;

    logic [96:0] exp_q[$];
    logic [31:0] exp_pc;
    bit          pending;
    logic [31:0] pend_addr;
    bit          prev_consume;
    logic [31:0] acc_addr[$];
    int          acc_cyc[$];

    task automatic chk(input string nm, input logic [96:0] act,
                       input logic [96:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5a5a1234;
    endfunction

    // One clock of stimulus plus the reference model update for that cycle.
    task automatic step();
        logic [31:0] r;
        logic        accept;
        @(negedge clk);
        cyc++;
        if (mode == 0) begin
            bp_taken          = (bp_pc == 32'h1c000010);
            bp_next_pc        = bp_taken ? 32'h1c000100 : bp_pc + 32'd4;
            inst_sram_addr_ok = 1'b1;
            inst_sram_data_ok = pending;
            ds_allowin        = 1'b1;
            redirect_valid    = 1'b0;
        end else begin
            r                 = $urandom;
            bp_taken          = ($urandom_range(3) == 0);
            bp_next_pc        = bp_taken ? {16'h1c00, r[15:2], 2'b00}
                                         : bp_pc + 32'd4;
            inst_sram_addr_ok = ($urandom_range(1) == 1);
            inst_sram_data_ok = pending && ($urandom_range(4) < 3);
            ds_allowin        = ($urandom_range(4) < 3);
            redirect_valid    = ($urandom_range(9) == 0);
            r                 = $urandom;
            redirect_pc       = {16'h1c00, r[15:0]};
        end
        inst_sram_rdata = pending ? mem(pend_addr) : $urandom;
        #1;
        if (prev_consume) chk("req_after_consume", inst_sram_req, 1'b1);
        prev_consume = fs_to_ds_valid && ds_allowin && !redirect_valid;
        chk("bp_pc", bp_pc, exp_pc);
        if (inst_sram_req) begin
            chk("addr", inst_sram_addr, {exp_pc[31:2], 2'b00});
            chk("one_outstanding", pending, 1'b0);
        end
        if (pending && inst_sram_data_ok) pending = 1'b0;
        accept = inst_sram_req && inst_sram_addr_ok;
        if (accept) begin
            pending   = 1'b1;
            pend_addr = inst_sram_addr;
            acc_addr.push_back(inst_sram_addr);
            acc_cyc.push_back(cyc);
        end
        if (redirect_valid) begin
            exp_q.delete();
            exp_pc = redirect_pc;
        end else if (accept) begin
            exp_q.push_back({exp_pc, mem({exp_pc[31:2], 2'b00}),
                             bp_taken, bp_next_pc});
            exp_pc = bp_next_pc;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset             = 1'b1;
        redirect_valid    = 1'b0;
        inst_sram_addr_ok = 1'b0;
        inst_sram_data_ok = 1'b0;
        ds_allowin        = 1'b0;
        bp_taken          = 1'b0;
        bp_next_pc        = 32'h0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", inst_sram_req, 1'b0);
        chk("rst_valid", fs_to_ds_valid, 1'b0);
        chk("rst_bus", fs_to_ds_bus, 97'h0);
        chk("rst_bp_pc", bp_pc, RST);
        chk("rst_addr", inst_sram_addr, RST);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("req_after_reset", inst_sram_req, 1'b1);
        exp_q.delete();
        pending      = 1'b0;
        exp_pc       = RST;
        prev_consume = 1'b0;
        acc_addr.delete();
        acc_cyc.delete();
        cyc = 0;
    endtask

    // Monitor: checks whatever decode would see, independent of stimulus.
    initial begin
        logic [96:0] prev_bus;
        bit          hold;
        hold     = 1'b0;
        prev_bus = 97'h0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                hold = 1'b0;
            end else begin
                if (fs_to_ds_valid) begin
                    chk("req_low_while_full", inst_sram_req, 1'b0);
                    if (hold) chk("bus_stable", fs_to_ds_bus, prev_bus);
                    if (!redirect_valid) begin
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_output: got %h expected none",
                                     fs_to_ds_bus);
                        end else if (ds_allowin) begin
                            chk("bus", fs_to_ds_bus, exp_q.pop_front());
                            consumed++;
                        end
                    end
                end
                hold     = fs_to_ds_valid && !ds_allowin && !redirect_valid;
                prev_bus = fs_to_ds_bus;
            end
        end
    end

    initial begin
        logic [31:0] seq[6];
        seq[0] = 32'h1c000000;
        seq[1] = 32'h1c000004;
        seq[2] = 32'h1c000008;
        seq[3] = 32'h1c00000c;
        seq[4] = 32'h1c000010;
        seq[5] = 32'h1c000100;
        reset       = 1'b1;
        redirect_pc = 32'h0;
        exp_pc      = RST;
        pending     = 1'b0;
        prev_consume = 1'b0;

        do_reset();
        mode = 0;
        repeat (20) step();
        if (acc_addr.size() < 6) begin
            tests++;
            fails++;
            $display("FAIL seq_count: got %0d expected 6", acc_addr.size());
        end else begin
            for (int i = 0; i < 6; i++) chk("seq_addr", acc_addr[i], seq[i]);
            chk("seq_gap1", 32'(acc_cyc[1] - acc_cyc[0]), 32'd3);
            chk("seq_gap2", 32'(acc_cyc[2] - acc_cyc[1]), 32'd3);
        end

        mode = 1;
        consumed = 0;
        repeat (3000) step();
        chk("throughput", consumed > 100, 1'b1);

        do_reset();
        mode = 0;
        repeat (6) step();
        if (acc_addr.size() == 0) begin
            tests++;
            fails++;
            $display("FAIL post_reset_fetch: got none expected %h", RST);
        end else begin
            chk("post_reset_fetch", acc_addr[0], RST);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
